// File: rtl/psum_pkg.sv
// Shared PSUM-memory definitions: arbiter state encoding and default widths,
// used by the PSUM arbiter and the SFU controller.
package psum_pkg;

   localparam int unsigned PSUM_ADDR_W   = 11;
   localparam int unsigned PSUM_DATA_W   = 128;
   localparam int unsigned PSUM_MAX_WAIT = 8;
   localparam int unsigned WAIT_W        = 4;

   typedef enum logic [1:0] {
      StIdle,
      StOwnA,
      StOwnS,
      StLockS
   } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant decision (array vs SFU) with SFU lock and
// array force-through; purely combinational.
module rr_arb2 (
   input  logic a_req,
   input  logic s_req,
   input  logic prio_s,
   input  logic lock,
   input  logic force_a,
   output logic a_gnt,
   output logic s_gnt
);

   always_comb begin
      a_gnt = 1'b0;
      s_gnt = 1'b0;
      if (a_req && s_req) begin
         // A held lock wins unless the array has starved long enough
         if (lock && !force_a) begin
            s_gnt = 1'b1;
         end else if (lock) begin
            a_gnt = 1'b1;
         end else if (prio_s) begin
            s_gnt = 1'b1;
         end else begin
            a_gnt = 1'b1;
         end
      end else begin
         a_gnt = a_req;
         s_gnt = s_req;
      end
   end

endmodule

// File: rtl/psum_mem_arbiter.sv
// PSUM memory arbiter between the OFIFO drain (array) and the SFU, with
// registered memory command and a 2-cycle read return. Optional stats: PSUM_ARB_STATS_EN.
module psum_mem_arbiter
   import psum_pkg::*;
#(
   parameter int unsigned ADDR_W   = PSUM_ADDR_W,
   parameter int unsigned DATA_W   = PSUM_DATA_W,
   parameter int unsigned MAX_WAIT = PSUM_MAX_WAIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   input  logic              s_req,
   input  logic              s_we,
   input  logic              s_lock,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_wdata,
   output logic              s_gnt,
   output logic              s_rvalid,
   output logic [DATA_W-1:0] s_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef PSUM_ARB_STATS_EN
   ,
   output logic [15:0]       stat_conflicts,
   output logic [15:0]       stat_lock_breaks
`endif
);

   localparam logic [WAIT_W-1:0] WaitLimit = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WaitSat   = '1;

   arb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              rd_p1_q, rd_p2_q;
   logic [DATA_W-1:0] rdata_hold_q;
   logic              lock, force_a, prio_s;

   assign lock    = (state_q == StLockS) && s_lock;
   assign force_a = wait_q >= WaitLimit;
   // Leaving a lock falls into the "array next" branch, like OWN_S
   assign prio_s  = (state_q == StIdle) || (state_q == StOwnA);

   rr_arb2 u_rr_arb2 (
      .a_req   (a_req),
      .s_req   (s_req),
      .prio_s  (prio_s),
      .lock    (lock),
      .force_a (force_a),
      .a_gnt   (a_gnt),
      .s_gnt   (s_gnt)
   );

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      if (!a_req && !s_req) begin
         state_d = StIdle;
      end else if (a_gnt) begin
         state_d = StOwnA;
      end else if (s_gnt) begin
         state_d = s_lock ? StLockS : StOwnS;
      end
      if (a_gnt || !a_req) begin
         wait_d = '0;
      end else if (wait_q != WaitSat) begin
         wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         wait_q       <= '0;
         rd_p1_q      <= 1'b0;
         rd_p2_q      <= 1'b0;
         rdata_hold_q <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         rd_p1_q <= s_gnt && !s_we;
         rd_p2_q <= rd_p1_q;
         if (rd_p2_q) begin
            rdata_hold_q <= mem_rdata;
         end
         mem_en <= a_gnt || s_gnt;
         mem_we <= a_gnt || (s_gnt && s_we);
         if (a_gnt || s_gnt) begin
            mem_addr  <= a_gnt ? a_addr : s_addr;
            mem_wdata <= a_gnt ? a_wdata : s_wdata;
         end
      end
   end

   assign s_rvalid = rd_p2_q;
   assign s_rdata  = rd_p2_q ? mem_rdata : rdata_hold_q;

`ifdef PSUM_ARB_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_conflicts   <= '0;
         stat_lock_breaks <= '0;
      end else begin
         if (a_req && s_req && (stat_conflicts != 16'hFFFF)) begin
            stat_conflicts <= stat_conflicts + 16'd1;
         end
         if (lock && force_a && a_gnt && (stat_lock_breaks != 16'hFFFF)) begin
            stat_lock_breaks <= stat_lock_breaks + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Directed bench for psum_mem_arbiter with a read-return scoreboard.
module tb_psum_mem_arbiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         a_req;
   logic [10:0]  a_addr;
   logic [127:0] a_wdata;
   logic         a_gnt;
   logic         s_req, s_we, s_lock;
   logic [10:0]  s_addr;
   logic [127:0] s_wdata;
   logic         s_gnt;
   logic         s_rvalid;
   logic [127:0] s_rdata;
   logic         mem_en, mem_we;
   logic [10:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
`ifdef PSUM_ARB_STATS_EN
   logic [15:0]  stat_conflicts, stat_lock_breaks;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [127:0] sb_data[$];
   int           sb_cyc[$];

   psum_mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_gnt     (a_gnt),
      .s_req     (s_req),
      .s_we      (s_we),
      .s_lock    (s_lock),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_gnt     (s_gnt),
      .s_rvalid  (s_rvalid),
      .s_rdata   (s_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef PSUM_ARB_STATS_EN
      ,
      .stat_conflicts   (stat_conflicts),
      .stat_lock_breaks (stat_lock_breaks)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] pat(input logic [10:0] a);
      if (a == 11'd37) return 128'hAB;
      return {8{5'b0, a}} ^ 128'h1;
   endfunction

   // Read-only memory model: data one cycle after a read command
   always @(posedge clk) if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ar, input logic [10:0] aa, input logic sr, input logic sw,
                       input logic sl, input logic [10:0] sa, input string tag,
                       input logic ea, input logic es);
      @(negedge clk);
      a_req   = ar;
      a_addr  = aa;
      a_wdata = {4{21'h0, aa}};
      s_req   = sr;
      s_we    = sw;
      s_lock  = sl;
      s_addr  = sa;
      s_wdata = ~{4{21'h0, sa}};
      #1;
      check({tag, "_agnt"}, a_gnt, ea);
      check({tag, "_sgnt"}, s_gnt, es);
      if (s_gnt && !s_we) begin
         sb_data.push_back(pat(s_addr));
         sb_cyc.push_back(cyc + 2);
      end
   endtask

   task automatic idle(input string tag);
      step(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 11'd0, tag, 1'b0, 1'b0);
   endtask

   task automatic check_mem(input string tag, input logic en, input logic we,
                            input logic [10:0] addr);
      @(posedge clk);
      #1;
      check({tag, "_mem_en"}, mem_en, en);
      if (en) begin
         check({tag, "_mem_we"}, mem_we, we);
         check({tag, "_mem_addr"}, mem_addr, addr);
      end
   endtask

   always @(negedge clk) begin
      logic [127:0] exp_d;
      int           exp_c;
      if (reset && s_rvalid) begin
         if (sb_data.size() == 0) begin
            check("rvalid_unexpected", s_rvalid, 1'b0);
         end else begin
            exp_d = sb_data.pop_front();
            exp_c = sb_cyc.pop_front();
            check("rdata", s_rdata, exp_d);
            check("rlatency", cyc, exp_c);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      a_req = 1'b0; a_addr = '0; a_wdata = '0;
      s_req = 1'b0; s_we = 1'b0; s_lock = 1'b0; s_addr = '0; s_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 11'd0);
      check("rst_mem_wdata", mem_wdata, 128'd0);
      check("rst_rvalid", s_rvalid, 1'b0);
      check("rst_rdata", s_rdata, 128'd0);
`ifdef PSUM_ARB_STATS_EN
      check("rst_conflicts", stat_conflicts, 16'd0);
      check("rst_lock_breaks", stat_lock_breaks, 16'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      idle("idle0");

      // Array write alone
      step(1'b1, 11'd5, 1'b0, 1'b0, 1'b0, 11'd0, "a_only", 1'b1, 1'b0);
      check_mem("a_only", 1'b1, 1'b1, 11'd5);
      check("a_only_wdata", mem_wdata, {4{21'h0, 11'd5}});
      idle("gap");
      check_mem("gap", 1'b0, 1'b0, 11'd0);

      // SFU read of 37, returned two cycles after grant
      step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 11'd37, "s_rd", 1'b0, 1'b1);
      check_mem("s_rd", 1'b1, 1'b0, 11'd37);
      repeat (3) idle("s_rd_wait");
      check("s_rd_drained", sb_data.size(), 0);
      check("s_rd_hold", s_rdata, 128'hAB);

      // SFU write
      step(1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 11'd12, "s_wr", 1'b0, 1'b1);
      check_mem("s_wr", 1'b1, 1'b1, 11'd12);
      idle("idle1");

      // Round robin from IDLE: S,A,S,A,...
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 11'd100, 1'b1, 1'b1, 1'b0, 11'd200, "rr",
              1'(i % 2), 1'(1 - (i % 2)));
      end
      idle("idle2");

      // Lock held: 8 SFU grants, one forced array grant, then relock
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 11'd7, 1'b1, 1'b1, 1'b1, 11'd8, "lock", 1'b0, 1'b1);
      end
      step(1'b1, 11'd7, 1'b1, 1'b1, 1'b1, 11'd8, "lock_break", 1'b1, 1'b0);
      check_mem("lock_break", 1'b1, 1'b1, 11'd7);
      step(1'b1, 11'd7, 1'b1, 1'b1, 1'b1, 11'd8, "relock", 1'b0, 1'b1);
      idle("idle3");
      check_mem("idle3", 1'b0, 1'b0, 11'd0);
`ifdef PSUM_ARB_STATS_EN
      check("stat_lock_breaks", stat_lock_breaks, 16'd1);
      check("stat_conflicts", stat_conflicts, 16'd18);
`endif

      // Back-to-back reads 0..3, reset lands after the first two returns
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 11'(i), "b2b_rd", 1'b0, 1'b1);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      a_req = 1'b0;
      s_req = 1'b0;
      #1;
      check("flush_pending", sb_data.size(), 2);
      check("flush_rvalid", s_rvalid, 1'b0);
      check("flush_mem_en", mem_en, 1'b0);
      check("flush_rdata", s_rdata, 128'd0);
      sb_data.delete();
      sb_cyc.delete();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("post_rst_rvalid", s_rvalid, 1'b0);
      end
      step(1'b1, 11'd3, 1'b1, 1'b1, 1'b0, 11'd4, "post_rst_idle", 1'b0, 1'b1);
      idle("idle4");
      repeat (3) idle("tail");
      check("sb_empty_end", sb_data.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/psum_mem_arbiter.md
PSUM_MEM_ARBITER -- requirements
Module: psum_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, PSUM memory address width.
REQ-002 SHALL have parameter DATA_W, default 128, PSUM word width (num_oc x 16).
REQ-003 SHALL have parameter MAX_WAIT, default 8, wait cycles before a lock is broken.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port a_req  input  1  array (OFIFO drain) write request.
REQ-007 SHALL have ports a_addr input ADDR_W and a_wdata input DATA_W, the array write address and data.
REQ-008 SHALL have port a_gnt  output  1  array request accepted this cycle.
REQ-009 SHALL have ports s_req input 1, s_we input 1, s_lock input 1, s_addr input ADDR_W and s_wdata input DATA_W: SFU request, write-not-read, hold-ownership, address, write data.
REQ-010 SHALL have port s_gnt  output  1  SFU request accepted this cycle.
REQ-011 SHALL have ports s_rvalid output 1 and s_rdata output DATA_W, SFU read return.
REQ-012 SHALL have ports mem_en output 1, mem_we output 1, mem_addr output ADDR_W and mem_wdata output DATA_W, the registered memory command.
REQ-013 SHALL have port mem_rdata  input  DATA_W  memory read data, valid one cycle after a read command.

Function
REQ-014 SHALL compute grants combinationally from the requests and registered state; at most one of a_gnt and s_gnt is high per cycle.
REQ-015 SHALL raise a_gnt or s_gnt only when the matching request is high.
REQ-016 SHALL register the granted command into mem_* on the next edge; mem_en is 0 in any cycle following a cycle with no grant.
REQ-017 SHALL keep FSM states IDLE, OWN_A, OWN_S and LOCK_S, recording the last owner.
REQ-018 SHALL, from IDLE, grant the SFU when both requesters are high; OWN_A prefers the SFU next, OWN_S prefers the array next (round-robin).
REQ-019 SHALL enter LOCK_S when the SFU is granted with s_lock=1; in LOCK_S the SFU has priority while s_lock=1.
REQ-020 SHALL leave LOCK_S when s_lock falls, or when a_req has waited MAX_WAIT cycles; then grant the array once and go to OWN_A.
REQ-021 SHALL count consecutive cycles with a_req=1 and a_gnt=0 in a saturating 4-bit counter, cleared on a_gnt.
REQ-022 SHALL go to IDLE in any cycle with no request.
REQ-023 SHALL pipeline a read flag so that s_rvalid=1 exactly two cycles after a cycle with s_gnt=1 and s_we=0.
REQ-024 SHALL drive s_rdata from mem_rdata while s_rvalid=1, and hold the last value otherwise.
REQ-025 SHALL accept back-to-back SFU reads, one per cycle, with returns in issue order.
REQ-026 SHALL not reorder or drop any granted command; ungranted requesters hold their inputs stable until granted.

Reset
REQ-027 SHALL, on reset low, force IDLE, wait counter 0, read pipeline empty, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, s_rvalid=0 and s_rdata=0.
REQ-028 SHALL discard in-flight reads when reset is asserted mid-operation, with no s_rvalid after release.

Configuration
REQ-029 SHALL, with PSUM_ARB_STATS_EN defined, provide output stat_conflicts (16 bits) and output stat_lock_breaks (16 bits): saturating counts of cycles with both requests high and of forced lock breaks, both reset to 0.
REQ-030 SHALL, without PSUM_ARB_STATS_EN, omit both ports and counters, with arbitration behaviour identical.

Structure
REQ-031 SHALL take the state encoding and the default widths from a shared package psum_pkg, also used by the SFU controller.
REQ-032 SHALL place the grant decision in one sub-module rr_arb2 (two-way round-robin with lock and force inputs); the pipeline and command registers stay in the top.

Verification
REQ-033 SHALL check: a_req only, a_addr=5 -> a_gnt the same cycle; next cycle mem_en=1, mem_we=1, mem_addr=5.
REQ-034 SHALL check: SFU read addr=37, mem_rdata=0xAB after the command -> s_rvalid=1 with s_rdata=0xAB, two cycles after s_gnt.
REQ-035 SHALL check: both requesting continuously, no lock, from IDLE -> grants alternate S,A,S,A for 8 cycles.
REQ-036 SHALL check: s_lock=1 held with a_req=1 -> SFU granted 8 cycles, then one forced a_gnt; with PSUM_ARB_STATS_EN defined, stat_lock_breaks=1.
REQ-037 SHALL check: four back-to-back SFU reads to addrs 0..3, then reset low -> only returns completed before reset are seen; s_rvalid=0 after release.
